// File: rtl/dispatcher_pkg.sv
// Shared widths, opcode encodings and the reserved "no rename" tag for the dispatch stage.
package dispatcher_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned AddrW = 32;
    localparam int unsigned ImmW  = 32;
    localparam int unsigned OpW   = 6;
    localparam int unsigned NameW = 5;
    localparam int unsigned NickW = 4;

    // Tag 0 means the operand value is already final.
    localparam logic [NickW-1:0] NickNone = '0;

    typedef enum logic [OpW-1:0] {
        OpNop = 6'd0,
        OpAdd = 6'd1,
        OpSub = 6'd2,
        OpLb  = 6'd16,
        OpLh  = 6'd17,
        OpLw  = 6'd18,
        OpLbu = 6'd19,
        OpLhu = 6'd20,
        OpSb  = 6'd24,
        OpSh  = 6'd25,
        OpSw  = 6'd26
    } op_e;

    function automatic logic is_store(input logic [OpW-1:0] op);
        return (op == OpSb) || (op == OpSh) || (op == OpSw);
    endfunction

    function automatic logic is_mem(input logic [OpW-1:0] op);
        return (op == OpLb) || (op == OpLh) || (op == OpLw) || (op == OpLbu) ||
               (op == OpLhu) || is_store(op);
    endfunction

endpackage

// File: rtl/dispatcher_operand_resolve.sv
// Resolves one operand: the incoming regfile operand against CDBs/ROB, and the held operand
// against the CDBs only (snoop). Both paths share the same tag compare.
module dispatcher_operand_resolve #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NICK_W = 4
) (
    input  logic [NICK_W-1:0] rf_nick_i,
    input  logic [DATA_W-1:0] rf_dt_i,
    input  logic              rob_rdy_i,
    input  logic [DATA_W-1:0] rob_dt_i,
    input  logic              alu_en_i,
    input  logic [NICK_W-1:0] alu_nick_i,
    input  logic [DATA_W-1:0] alu_dt_i,
    input  logic              lsb_en_i,
    input  logic [NICK_W-1:0] lsb_nick_i,
    input  logic [DATA_W-1:0] lsb_dt_i,
    input  logic [NICK_W-1:0] held_q_i,
    input  logic [DATA_W-1:0] held_v_i,
    output logic [DATA_W-1:0] cap_v_o,
    output logic [NICK_W-1:0] cap_q_o,
    output logic [DATA_W-1:0] snp_v_o,
    output logic [NICK_W-1:0] snp_q_o
);

    function automatic logic cdb_hit(input logic en, input logic [NICK_W-1:0] cdb_nick,
                                     input logic [NICK_W-1:0] q);
        return en && (q != '0) && (cdb_nick == q);
    endfunction

    always_comb begin
        cap_v_o = rf_dt_i;
        cap_q_o = rf_nick_i;
        if (rf_nick_i == '0) begin
            cap_q_o = '0;
        end else if (cdb_hit(alu_en_i, alu_nick_i, rf_nick_i)) begin
            cap_v_o = alu_dt_i;
            cap_q_o = '0;
        end else if (cdb_hit(lsb_en_i, lsb_nick_i, rf_nick_i)) begin
            cap_v_o = lsb_dt_i;
            cap_q_o = '0;
        end else if (rob_rdy_i) begin
            cap_v_o = rob_dt_i;
            cap_q_o = '0;
        end

        snp_v_o = held_v_i;
        snp_q_o = held_q_i;
        if (cdb_hit(alu_en_i, alu_nick_i, held_q_i)) begin
            snp_v_o = alu_dt_i;
            snp_q_o = '0;
        end else if (cdb_hit(lsb_en_i, lsb_nick_i, held_q_i)) begin
            snp_v_o = lsb_dt_i;
            snp_q_o = '0;
        end
    end

endmodule

// File: rtl/dispatcher.sv
// Dispatch stage: one-entry holding register between regfile and RS/LSB, with ROB tag
// allocation, rename write-back and operand resolution against ROB and both CDBs.
module dispatcher
    import dispatcher_pkg::*;
#(
    parameter int unsigned DATA_W = DataW,
    parameter int unsigned ADDR_W = AddrW,
    parameter int unsigned IMM_W  = ImmW,
    parameter int unsigned OP_W   = OpW,
    parameter int unsigned NAME_W = NameW,
    parameter int unsigned NICK_W = NickW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              iRF_en,
    input  logic [OP_W-1:0]   iRF_op,
    input  logic [ADDR_W-1:0] iRF_pc,
    input  logic [IMM_W-1:0]  iRF_imm,
    input  logic              iRF_pd,
    input  logic [NAME_W-1:0] iRF_rd_regnm,
    input  logic [DATA_W-1:0] iRF_rs1_dt,
    input  logic [DATA_W-1:0] iRF_rs2_dt,
    input  logic [NICK_W-1:0] iRF_rs1_nick,
    input  logic [NICK_W-1:0] iRF_rs2_nick,
    output logic              oIND_stall,
    input  logic              iROB_full,
    input  logic [NICK_W-1:0] iROB_nick,
    output logic              oROB_alloc,
    output logic [NICK_W-1:0] oROB_q1_nick,
    output logic [NICK_W-1:0] oROB_q2_nick,
    input  logic              iROB_q1_rdy,
    input  logic              iROB_q2_rdy,
    input  logic [DATA_W-1:0] iROB_q1_dt,
    input  logic [DATA_W-1:0] iROB_q2_dt,
    input  logic              iALU_cdb_en,
    input  logic [NICK_W-1:0] iALU_cdb_nick,
    input  logic [DATA_W-1:0] iALU_cdb_dt,
    input  logic              iLSB_cdb_en,
    input  logic [NICK_W-1:0] iLSB_cdb_nick,
    input  logic [DATA_W-1:0] iLSB_cdb_dt,
    input  logic              iRS_full,
    input  logic              iLSB_full,
    output logic              oRS_en,
    output logic              oLSB_en,
    output logic [OP_W-1:0]   oIS_op,
    output logic [ADDR_W-1:0] oIS_pc,
    output logic [IMM_W-1:0]  oIS_imm,
    output logic              oIS_pd,
    output logic [NICK_W-1:0] oIS_dest,
    output logic [DATA_W-1:0] oIS_v1,
    output logic [DATA_W-1:0] oIS_v2,
    output logic [NICK_W-1:0] oIS_q1,
    output logic [NICK_W-1:0] oIS_q2,
    output logic              oRF_nick_en,
    output logic [NAME_W-1:0] oRF_nick_regnm,
    output logic [NICK_W-1:0] oRF_nick
);

    logic              hold_q, hold_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [IMM_W-1:0]  imm_q, imm_d;
    logic              pd_q, pd_d;
    logic [NAME_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] v1_q, v1_d, v2_q, v2_d;
    logic [NICK_W-1:0] q1_q, q1_d, q2_q, q2_d;

    logic              rs_en_q, rs_en_d, lsb_en_q, lsb_en_d;
    logic [OP_W-1:0]   is_op_q, is_op_d;
    logic [ADDR_W-1:0] is_pc_q, is_pc_d;
    logic [IMM_W-1:0]  is_imm_q, is_imm_d;
    logic              is_pd_q, is_pd_d;
    logic [NICK_W-1:0] is_dest_q, is_dest_d;
    logic [DATA_W-1:0] is_v1_q, is_v1_d, is_v2_q, is_v2_d;
    logic [NICK_W-1:0] is_q1_q, is_q1_d, is_q2_q, is_q2_d;

    logic              mem, store, fire, capture, rename_en;
    logic [DATA_W-1:0] cap_v1, cap_v2, snp_v1, snp_v2;
    logic [NICK_W-1:0] cap_q1, cap_q2, snp_q1, snp_q2;

    dispatcher_operand_resolve #(.DATA_W(DATA_W), .NICK_W(NICK_W)) u_rs1 (
        .rf_nick_i (iRF_rs1_nick),
        .rf_dt_i   (iRF_rs1_dt),
        .rob_rdy_i (iROB_q1_rdy),
        .rob_dt_i  (iROB_q1_dt),
        .alu_en_i  (iALU_cdb_en),
        .alu_nick_i(iALU_cdb_nick),
        .alu_dt_i  (iALU_cdb_dt),
        .lsb_en_i  (iLSB_cdb_en),
        .lsb_nick_i(iLSB_cdb_nick),
        .lsb_dt_i  (iLSB_cdb_dt),
        .held_q_i  (q1_q),
        .held_v_i  (v1_q),
        .cap_v_o   (cap_v1),
        .cap_q_o   (cap_q1),
        .snp_v_o   (snp_v1),
        .snp_q_o   (snp_q1)
    );

    dispatcher_operand_resolve #(.DATA_W(DATA_W), .NICK_W(NICK_W)) u_rs2 (
        .rf_nick_i (iRF_rs2_nick),
        .rf_dt_i   (iRF_rs2_dt),
        .rob_rdy_i (iROB_q2_rdy),
        .rob_dt_i  (iROB_q2_dt),
        .alu_en_i  (iALU_cdb_en),
        .alu_nick_i(iALU_cdb_nick),
        .alu_dt_i  (iALU_cdb_dt),
        .lsb_en_i  (iLSB_cdb_en),
        .lsb_nick_i(iLSB_cdb_nick),
        .lsb_dt_i  (iLSB_cdb_dt),
        .held_q_i  (q2_q),
        .held_v_i  (v2_q),
        .cap_v_o   (cap_v2),
        .cap_q_o   (cap_q2),
        .snp_v_o   (snp_v2),
        .snp_q_o   (snp_q2)
    );

    // Comb strobes are qualified by rst and rdy so reset and freeze both silence them.
    always_comb begin
        mem          = is_mem(op_q);
        store        = is_store(op_q);
        fire         = rst && rdy && !clr && hold_q && !iROB_full &&
                       (mem ? !iLSB_full : !iRS_full);
        capture      = rst && rdy && !clr && iRF_en && (!hold_q || fire);
        rename_en    = fire && !store && (rd_q != '0);
        oROB_alloc   = fire;
        oIND_stall   = rst && rdy && hold_q && !fire;
        oRF_nick_en    = rename_en;
        oRF_nick_regnm = rename_en ? rd_q : '0;
        oRF_nick       = rename_en ? iROB_nick : '0;
        oROB_q1_nick = '0;
        oROB_q2_nick = '0;
        if (rst) begin
            oROB_q1_nick = capture ? iRF_rs1_nick : q1_q;
            oROB_q2_nick = capture ? iRF_rs2_nick : q2_q;
        end
    end

    always_comb begin
        hold_d    = hold_q;
        op_d      = op_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        pd_d      = pd_q;
        rd_d      = rd_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        q1_d      = q1_q;
        q2_d      = q2_q;
        rs_en_d   = rs_en_q;
        lsb_en_d  = lsb_en_q;
        is_op_d   = is_op_q;
        is_pc_d   = is_pc_q;
        is_imm_d  = is_imm_q;
        is_pd_d   = is_pd_q;
        is_dest_d = is_dest_q;
        is_v1_d   = is_v1_q;
        is_v2_d   = is_v2_q;
        is_q1_d   = is_q1_q;
        is_q2_d   = is_q2_q;
        if (rdy) begin
            rs_en_d  = fire && !mem;
            lsb_en_d = fire && mem;
            if (fire) begin
                is_op_d   = op_q;
                is_pc_d   = pc_q;
                is_imm_d  = imm_q;
                is_pd_d   = pd_q;
                is_dest_d = iROB_nick;
                is_v1_d   = snp_v1;
                is_v2_d   = snp_v2;
                is_q1_d   = snp_q1;
                is_q2_d   = snp_q2;
            end
            v1_d = snp_v1;
            v2_d = snp_v2;
            q1_d = snp_q1;
            q2_d = snp_q2;
            if (clr) begin
                hold_d = 1'b0;
            end else begin
                if (fire) hold_d = 1'b0;
                if (capture) begin
                    hold_d = 1'b1;
                    op_d   = iRF_op;
                    pc_d   = iRF_pc;
                    imm_d  = iRF_imm;
                    pd_d   = iRF_pd;
                    rd_d   = iRF_rd_regnm;
                    v1_d   = cap_v1;
                    v2_d   = cap_v2;
                    q1_d   = cap_q1;
                    q2_d   = cap_q2;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q    <= 1'b0;
            op_q      <= '0;
            pc_q      <= '0;
            imm_q     <= '0;
            pd_q      <= 1'b0;
            rd_q      <= '0;
            v1_q      <= '0;
            v2_q      <= '0;
            q1_q      <= '0;
            q2_q      <= '0;
            rs_en_q   <= 1'b0;
            lsb_en_q  <= 1'b0;
            is_op_q   <= '0;
            is_pc_q   <= '0;
            is_imm_q  <= '0;
            is_pd_q   <= 1'b0;
            is_dest_q <= '0;
            is_v1_q   <= '0;
            is_v2_q   <= '0;
            is_q1_q   <= '0;
            is_q2_q   <= '0;
        end else begin
            hold_q    <= hold_d;
            op_q      <= op_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            pd_q      <= pd_d;
            rd_q      <= rd_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            q1_q      <= q1_d;
            q2_q      <= q2_d;
            rs_en_q   <= rs_en_d;
            lsb_en_q  <= lsb_en_d;
            is_op_q   <= is_op_d;
            is_pc_q   <= is_pc_d;
            is_imm_q  <= is_imm_d;
            is_pd_q   <= is_pd_d;
            is_dest_q <= is_dest_d;
            is_v1_q   <= is_v1_d;
            is_v2_q   <= is_v2_d;
            is_q1_q   <= is_q1_d;
            is_q2_q   <= is_q2_d;
        end
    end

    assign oRS_en   = rs_en_q;
    assign oLSB_en  = lsb_en_q;
    assign oIS_op   = is_op_q;
    assign oIS_pc   = is_pc_q;
    assign oIS_imm  = is_imm_q;
    assign oIS_pd   = is_pd_q;
    assign oIS_dest = is_dest_q;
    assign oIS_v1   = is_v1_q;
    assign oIS_v2   = is_v2_q;
    assign oIS_q1   = is_q1_q;
    assign oIS_q2   = is_q2_q;

endmodule

// File: tb/tb_dispatcher.sv
// Bench for dispatcher: directed instruction stream, a slot-level reference model checked
// every cycle, and hand-computed expectations at key points.
module tb_dispatcher;
    import dispatcher_pkg::*;

    logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1, clr = 1'b0;
    logic        rf_en = 1'b0, rf_pd = 1'b0;
    logic [5:0]  rf_op = '0;
    logic [31:0] rf_pc = '0, rf_imm = '0, rs1_dt = '0, rs2_dt = '0;
    logic [4:0]  rf_rd = '0;
    logic [3:0]  rs1_nick = '0, rs2_nick = '0;
    logic        rob_full = 1'b0, rob_q1_rdy = 1'b0, rob_q2_rdy = 1'b0;
    logic [3:0]  rob_nick = 4'd1;
    logic [31:0] rob_q1_dt = '0, rob_q2_dt = '0;
    logic        alu_en = 1'b0, lsb_cdb_en = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;
    logic [3:0]  alu_nick = '0, lsb_nick = '0;
    logic [31:0] alu_dt = '0, lsb_dt = '0;

    logic        stall, alloc, rs_en, lsb_en, is_pd, nick_en;
    logic [3:0]  q1n, q2n, is_dest, is_q1, is_q2, nick_o;
    logic [5:0]  is_op;
    logic [31:0] is_pc, is_imm, is_v1, is_v2;
    logic [4:0]  nick_regnm;

    int n_tests = 0, n_fail = 0;
    logic [31:0] pc_ctr = 32'h1000;

    dispatcher dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .iRF_en(rf_en), .iRF_op(rf_op), .iRF_pc(rf_pc), .iRF_imm(rf_imm), .iRF_pd(rf_pd),
        .iRF_rd_regnm(rf_rd), .iRF_rs1_dt(rs1_dt), .iRF_rs2_dt(rs2_dt),
        .iRF_rs1_nick(rs1_nick), .iRF_rs2_nick(rs2_nick), .oIND_stall(stall),
        .iROB_full(rob_full), .iROB_nick(rob_nick), .oROB_alloc(alloc),
        .oROB_q1_nick(q1n), .oROB_q2_nick(q2n), .iROB_q1_rdy(rob_q1_rdy),
        .iROB_q2_rdy(rob_q2_rdy), .iROB_q1_dt(rob_q1_dt), .iROB_q2_dt(rob_q2_dt),
        .iALU_cdb_en(alu_en), .iALU_cdb_nick(alu_nick), .iALU_cdb_dt(alu_dt),
        .iLSB_cdb_en(lsb_cdb_en), .iLSB_cdb_nick(lsb_nick), .iLSB_cdb_dt(lsb_dt),
        .iRS_full(rs_full), .iLSB_full(lsb_full), .oRS_en(rs_en), .oLSB_en(lsb_en),
        .oIS_op(is_op), .oIS_pc(is_pc), .oIS_imm(is_imm), .oIS_pd(is_pd), .oIS_dest(is_dest),
        .oIS_v1(is_v1), .oIS_v2(is_v2), .oIS_q1(is_q1), .oIS_q2(is_q2),
        .oRF_nick_en(nick_en), .oRF_nick_regnm(nick_regnm), .oRF_nick(nick_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the pending instruction slot and the expected issue-bus contents.
    bit          m_valid = 0, m_hold = 0, m_pd = 0;
    logic [5:0]  m_op = '0;
    logic [31:0] m_pc = '0, m_imm = '0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_v[2] = '{0, 0};
    logic [3:0]  m_q[2] = '{0, 0};
    bit          e_rs = 0, e_lsb = 0, e_pd = 0;
    logic [5:0]  e_op = '0;
    logic [31:0] e_pc = '0, e_imm = '0;
    logic [3:0]  e_dest = '0;
    logic [31:0] e_v[2] = '{0, 0};
    logic [3:0]  e_q[2] = '{0, 0};

    function automatic bit m_is_store(input logic [5:0] op);
        return op inside {OpSb, OpSh, OpSw};
    endfunction

    function automatic bit m_is_mem(input logic [5:0] op);
        return m_is_store(op) || (op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu});
    endfunction

    // A tag is satisfied by whichever source has its value now: ALU CDB, LSB CDB, then ROB.
    task automatic resolve(input logic [3:0] n, input logic [31:0] d, input bit use_rob,
                           input bit rr, input logic [31:0] rd, output logic [31:0] v,
                           output logic [3:0] q);
        v = d;
        q = n;
        if (n == 0) q = 0;
        else if (alu_en && alu_nick == n) begin v = alu_dt; q = 0; end
        else if (lsb_cdb_en && lsb_nick == n) begin v = lsb_dt; q = 0; end
        else if (use_rob && rr) begin v = rd; q = 0; end
    endtask

    always @(negedge clk) begin
        bit f, cap, mem;
        logic [31:0] sv[2];
        logic [3:0] sq[2];
        if (m_valid) begin
            chk("rs_en", {31'b0, rs_en}, {31'b0, e_rs});
            chk("lsb_en", {31'b0, lsb_en}, {31'b0, e_lsb});
            if (e_rs || e_lsb) begin
                chk("is_op", {26'b0, is_op}, {26'b0, e_op});
                chk("is_pc", is_pc, e_pc);
                chk("is_imm", is_imm, e_imm);
                chk("is_pd", {31'b0, is_pd}, {31'b0, e_pd});
                chk("is_dest", {28'b0, is_dest}, {28'b0, e_dest});
                chk("is_q1", {28'b0, is_q1}, {28'b0, e_q[0]});
                chk("is_q2", {28'b0, is_q2}, {28'b0, e_q[1]});
                if (e_q[0] == 0) chk("is_v1", is_v1, e_v[0]);
                if (e_q[1] == 0) chk("is_v2", is_v2, e_v[1]);
            end
        end
        mem = m_is_mem(m_op);
        f = rst && rdy && !clr && m_hold && !rob_full && (mem ? !lsb_full : !rs_full);
        cap = rst && rdy && !clr && rf_en && (!m_hold || f);
        chk("alloc", {31'b0, alloc}, {31'b0, f});
        chk("stall", {31'b0, stall}, {31'b0, rst && rdy && m_hold && !f});
        if (f && !m_is_store(m_op) && m_rd != 0) begin
            chk("nick_en", {31'b0, nick_en}, 32'd1);
            chk("nick_regnm", {27'b0, nick_regnm}, {27'b0, m_rd});
            chk("nick", {28'b0, nick_o}, {28'b0, rob_nick});
        end else begin
            chk("nick_en", {31'b0, nick_en}, 32'd0);
        end
        if (!rst) begin
            chk("q1_nick", {28'b0, q1n}, 32'd0);
            chk("q2_nick", {28'b0, q2n}, 32'd0);
        end else if (cap) begin
            chk("q1_nick", {28'b0, q1n}, {28'b0, rs1_nick});
            chk("q2_nick", {28'b0, q2n}, {28'b0, rs2_nick});
        end else if (m_hold) begin
            chk("q1_nick", {28'b0, q1n}, {28'b0, m_q[0]});
            chk("q2_nick", {28'b0, q2n}, {28'b0, m_q[1]});
        end
        if (!rst) begin
            m_hold = 0; e_rs = 0; e_lsb = 0; m_valid = 1;
        end else if (rdy) begin
            for (int i = 0; i < 2; i++) resolve(m_q[i], m_v[i], 0, 0, 0, sv[i], sq[i]);
            e_rs = f && !mem;
            e_lsb = f && mem;
            if (f) begin
                e_op = m_op; e_pc = m_pc; e_imm = m_imm; e_pd = m_pd; e_dest = rob_nick;
                e_v = sv; e_q = sq;
            end
            m_v = sv;
            m_q = sq;
            if (clr) m_hold = 0;
            else begin
                if (f) m_hold = 0;
                if (cap) begin
                    m_hold = 1; m_op = rf_op; m_pc = rf_pc; m_imm = rf_imm; m_pd = rf_pd;
                    m_rd = rf_rd;
                    resolve(rs1_nick, rs1_dt, 1, rob_q1_rdy, rob_q1_dt, m_v[0], m_q[0]);
                    resolve(rs2_nick, rs2_dt, 1, rob_q2_rdy, rob_q2_dt, m_v[1], m_q[1]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] d1,
                         input logic [3:0] n1, input logic [31:0] d2, input logic [3:0] n2);
        rf_en = 1; rf_op = op; rf_rd = rd; rf_pd = rd[0];
        rf_pc = pc_ctr; rf_imm = pc_ctr ^ 32'h00ab_0000; pc_ctr += 4;
        rs1_dt = d1; rs1_nick = n1; rs2_dt = d2; rs2_nick = n2;
    endtask

    task automatic idle();
        rf_en = 0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_rs_en", {31'b0, rs_en}, 0); chk("rst_lsb_en", {31'b0, lsb_en}, 0);
        chk("rst_stall", {31'b0, stall}, 0); chk("rst_alloc", {31'b0, alloc}, 0);
        chk("rst_is_v1", is_v1, 0); chk("rst_is_dest", {28'b0, is_dest}, 0);
        rst = 1;
        tick();

        // ADD with ready operands, rd=3, tag 4.
        rob_nick = 4; instr(OpAdd, 3, 5, 0, 7, 0);
        tick(); idle(); #1;
        chk("add_alloc", {31'b0, alloc}, 1); chk("add_nick_en", {31'b0, nick_en}, 1);
        chk("add_regnm", {27'b0, nick_regnm}, 3); chk("add_nick", {28'b0, nick_o}, 4);
        chk("add_stall", {31'b0, stall}, 0);
        tick();
        chk("add_rs_en", {31'b0, rs_en}, 1); chk("add_lsb_en", {31'b0, lsb_en}, 0);
        chk("add_v1", is_v1, 5); chk("add_v2", is_v2, 7);
        chk("add_q1", {28'b0, is_q1}, 0); chk("add_dest", {28'b0, is_dest}, 4);

        // Store: no rename even with a nonzero rd field.
        rob_nick = 5; instr(OpSw, 5, 32'h40, 0, 32'h99, 0);
        tick(); idle(); #1;
        chk("sw_alloc", {31'b0, alloc}, 1); chk("sw_nick_en", {31'b0, nick_en}, 0);
        tick();
        chk("sw_lsb_en", {31'b0, lsb_en}, 1); chk("sw_rs_en", {31'b0, rs_en}, 0);
        chk("sw_v2", is_v2, 32'h99); chk("sw_dest", {28'b0, is_dest}, 5);

        // rd=0: issues but no rename.
        rob_nick = 6; instr(OpAdd, 0, 1, 0, 2, 0);
        tick(); idle(); #1;
        chk("rd0_nick_en", {31'b0, nick_en}, 0); chk("rd0_alloc", {31'b0, alloc}, 1);
        tick();
        chk("rd0_rs_en", {31'b0, rs_en}, 1); chk("rd0_dest", {28'b0, is_dest}, 6);

        // LW waiting on tag 2, LSB full; ALU CDB resolves it in hold.
        rob_nick = 7; lsb_full = 1; instr(OpLw, 9, 32'hdead, 2, 8, 0); #1;
        chk("lw_lookup", {28'b0, q1n}, 2);
        tick(); idle(); #1;
        chk("lw_stall", {31'b0, stall}, 1); chk("lw_noalloc", {31'b0, alloc}, 0);
        tick();
        alu_en = 1; alu_nick = 2; alu_dt = 32'h100;
        tick(); alu_en = 0; #1;
        chk("lw_snooped", {28'b0, q1n}, 0);
        tick(); lsb_full = 0; #1;
        chk("lw_alloc", {31'b0, alloc}, 1); chk("lw_regnm", {27'b0, nick_regnm}, 9);
        tick();
        chk("lw_lsb_en", {31'b0, lsb_en}, 1); chk("lw_v1", is_v1, 32'h100);
        chk("lw_q1", {28'b0, is_q1}, 0); chk("lw_dest", {28'b0, is_dest}, 7);

        // RS full for 3 cycles with a second ADD waiting behind the first.
        rs_full = 1; rob_nick = 8; instr(OpAdd, 1, 11, 0, 12, 0);
        tick(); instr(OpAdd, 2, 21, 0, 22, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_stall", {31'b0, stall}, 1); chk("full_noalloc", {31'b0, alloc}, 0);
            tick();
        end
        rs_full = 0; #1;
        chk("full_stall_off", {31'b0, stall}, 0); chk("full_nick_a", {28'b0, nick_o}, 8);
        tick(); rob_nick = 9; idle(); #1;
        chk("full_rs_a", {31'b0, rs_en}, 1); chk("full_v1_a", is_v1, 11);
        chk("full_regnm_b", {27'b0, nick_regnm}, 2); chk("full_alloc_b", {31'b0, alloc}, 1);
        tick();
        chk("full_rs_b", {31'b0, rs_en}, 1); chk("full_v1_b", is_v1, 21);
        chk("full_dest_b", {28'b0, is_dest}, 9);
        tick();
        chk("full_rs_idle", {31'b0, rs_en}, 0);

        // Capture priority: ALU over LSB for rs1, ROB for rs2.
        rob_nick = 10; alu_en = 1; alu_nick = 3; alu_dt = 32'haaaa;
        lsb_cdb_en = 1; lsb_nick = 3; lsb_dt = 32'hbbbb; rob_q2_rdy = 1; rob_q2_dt = 32'h77;
        instr(OpSub, 4, 1, 3, 2, 5);
        tick(); alu_en = 0; lsb_cdb_en = 0; rob_q2_rdy = 0; idle();
        tick();
        chk("prio_v1", is_v1, 32'haaaa); chk("prio_v2", is_v2, 32'h77);
        chk("prio_op", {26'b0, is_op}, {26'b0, OpSub});

        // ROB full hold with LSB CDB snoop.
        rob_full = 1; rob_nick = 11; instr(OpAdd, 6, 0, 4, 5, 0);
        tick(); idle(); #1;
        chk("robfull_stall", {31'b0, stall}, 1); chk("robfull_noalloc", {31'b0, alloc}, 0);
        lsb_cdb_en = 1; lsb_nick = 4; lsb_dt = 32'hcc;
        tick(); lsb_cdb_en = 0; rob_full = 0; #1;
        chk("robfull_alloc", {31'b0, alloc}, 1);
        tick();
        chk("robfull_v1", is_v1, 32'hcc); chk("robfull_dest", {28'b0, is_dest}, 11);

        // Operand still pending at issue keeps its tag.
        rob_nick = 12; instr(OpAdd, 7, 0, 5, 3, 0);
        tick(); idle(); tick();
        chk("pend_q1", {28'b0, is_q1}, 5); chk("pend_rs_en", {31'b0, rs_en}, 1);

        // clr while holding.
        rs_full = 1; instr(OpAdd, 8, 1, 0, 1, 0);
        tick(); idle(); clr = 1; #1;
        chk("clr_noalloc", {31'b0, alloc}, 0); chk("clr_no_nick", {31'b0, nick_en}, 0);
        tick(); clr = 0; rs_full = 0; #1;
        chk("clr_stall", {31'b0, stall}, 0); chk("clr_alloc", {31'b0, alloc}, 0);
        chk("clr_rs_en", {31'b0, rs_en}, 0);
        tick();
        chk("clr_rs_en2", {31'b0, rs_en}, 0);

        // rdy=0 freezes a ready-to-fire slot.
        rob_nick = 13; instr(OpAdd, 9, 4, 0, 4, 0);
        tick(); idle(); rdy = 0; #1;
        chk("rdy_alloc", {31'b0, alloc}, 0); chk("rdy_stall", {31'b0, stall}, 0);
        chk("rdy_nick_en", {31'b0, nick_en}, 0);
        tick(); tick(); rdy = 1; #1;
        chk("rdy_resume", {31'b0, alloc}, 1); chk("rdy_nick", {28'b0, nick_o}, 13);
        tick();
        chk("rdy_rs_en", {31'b0, rs_en}, 1); chk("rdy_dest", {28'b0, is_dest}, 13);

        // Reset while holding drops the instruction.
        rs_full = 1; instr(OpAdd, 10, 0, 3, 0, 6);
        tick(); idle(); #1;
        chk("mrst_stall", {31'b0, stall}, 1); chk("mrst_q1n", {28'b0, q1n}, 3);
        rst = 0; #1;
        chk("mrst_stall0", {31'b0, stall}, 0); chk("mrst_q1n0", {28'b0, q1n}, 0);
        chk("mrst_q2n0", {28'b0, q2n}, 0); chk("mrst_alloc0", {31'b0, alloc}, 0);
        tick();
        chk("mrst_rs_en", {31'b0, rs_en}, 0); chk("mrst_lsb_en", {31'b0, lsb_en}, 0);
        chk("mrst_op", {26'b0, is_op}, 0); chk("mrst_pc", is_pc, 0);
        chk("mrst_imm", is_imm, 0); chk("mrst_v1", is_v1, 0); chk("mrst_v2", is_v2, 0);
        chk("mrst_dest", {28'b0, is_dest}, 0); chk("mrst_pd", {31'b0, is_pd}, 0);
        chk("mrst_nick_en", {31'b0, nick_en}, 0);
        rst = 1; rs_full = 0; #1;
        chk("mrst_dropped", {31'b0, alloc}, 0);
        tick();
        chk("mrst_no_issue", {31'b0, rs_en}, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
